register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port successor to the CPU32 register file. It has 3 combinational
//  read ports, 2 write ports, an optional zero register, same-cycle write->read bypass
//  and a per-register pending scoreboard for multi-cycle producers (load/mul). It sits
//  in the decode stage, feeds the ALU operand muxes and exposes busy flags to hazard logic.
// PARAMETERS
//  DW        32  data width of each register
//  DEPTH     32  number of registers (2..256); AW = $clog2(DEPTH)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, is never pending
//  BYPASS    1   1: a read returns the data being written to that register this cycle
// PORTS
//  CLK         in   1    clock, all state updates on rising edge
//  Reset       in   1    asynchronous, active-high; clears all registers and pending bits
//  RegWre0     in   1    write enable, port 0
//  WriteReg0   in   AW   write address, port 0
//  WriteData0  in   DW   write data, port 0
//  RegWre1     in   1    write enable, port 1 (priority port)
//  WriteReg1   in   AW   write address, port 1
//  WriteData1  in   DW   write data, port 1
//  ReadReg1..3 in   AW   read addresses
//  ReadData1..3 out DW   read data (combinational)
//  PendSet     in   1    mark PendReg as awaiting a multi-cycle result
//  PendReg     in   AW   register to mark pending
//  Busy1..3    out  1    pending status of ReadReg1..3 (combinational)
// BEHAVIOUR
//  - Reset high: all DEPTH registers = 0 and all pending bits = 0 at once, without
//    waiting for a clock edge. ReadData* = 0 and Busy* = 0 while Reset is held.
//    Writes and PendSet are ignored while Reset is held. Reset asserted mid-write
//    discards that write.
//  - Write: at posedge CLK, if RegWreN is set and WriteRegN is valid, reg[WriteRegN] <= WriteDataN.
//    A WriteRegN is valid when it is < DEPTH and is not (ZERO_REG && addr==0).
//    Invalid writes are dropped silently.
//  - Both ports write the same address in one cycle: port 1 data is stored. Port 0 is lost.
//  - Read: ReadDataK is combinational from ReadRegK. Read latency is 0 cycles.
//    ReadDataK = 0 if addr >= DEPTH, or if ZERO_REG && addr==0.
//    With BYPASS=1 and a valid write pending on ReadRegK this cycle, ReadDataK = WriteData.
//    If both ports write that address, the bypassed value is WriteData1.
//    With BYPASS=0, ReadDataK returns the stored value; new data is visible the next cycle.
//  - Scoreboard: one pending bit per register, DEPTH bits total.
//    At posedge, a valid write on either port clears pend[WriteRegN].
//    At posedge, PendSet with a valid PendReg sets pend[PendReg].
//    Set and clear of the same register in one cycle: set wins, because a new producer
//    was issued after the old result.
//    PendReg = 0 with ZERO_REG=1, or PendReg >= DEPTH: the request is ignored.
//  - BusyK = pend[ReadRegK], with one exception: it is 0 when BYPASS=1 and a valid write
//    to ReadRegK occurs this cycle, since the result is being forwarded now.
//  - Operand sizing: DW and AW are free. Writes store exactly DW bits; there is no
//    extension or truncation.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, then pulse Reset between clock edges
//    -> ReadData1(r5) = 0 immediately; Busy1..3 = 0.
//  2 Write then read: write r7 = 0x12345678 on port 0 with BYPASS=0 -> ReadData2 = 0 in
//    the same cycle and 0x12345678 after the edge. With BYPASS=1 -> 0x12345678 in the
//    same cycle.
//  3 Port conflict: port0 writes r3 = 0x11, port1 writes r3 = 0x22 in one cycle
//    -> bypassed value 0x22; stored value 0x22.
//  4 Zero register: write r0 = 0xFFFFFFFF and PendSet r0 -> ReadData* = 0 and Busy = 0
//    for r0, in the same cycle and after.
//  5 Scoreboard: PendSet r9, idle 3 cycles -> Busy3(r9) = 1. Write r9 = 0xA5 -> Busy3 = 0
//    in the write cycle (BYPASS=1) and stays 0 after. Same-cycle PendSet r9 + write r9
//    -> Busy = 1 after the edge.
//  6 Parameter sweep: DW=16, DEPTH=12 -> write to addr 13 is dropped; ReadData for
//    addr 13 = 0; r11 is fully usable.

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and pending scoreboard
// Three combinational read ports, two write ports (port 1 wins on address conflict).
module register_file_mp #(
    parameter int  DW       = 32,
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          RegWre0,
    input  logic [AW-1:0] WriteReg0,
    input  logic [DW-1:0] WriteData0,
    input  logic          RegWre1,
    input  logic [AW-1:0] WriteReg1,
    input  logic [DW-1:0] WriteData1,
    input  logic [AW-1:0] ReadReg1,
    input  logic [AW-1:0] ReadReg2,
    input  logic [AW-1:0] ReadReg3,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    output logic [DW-1:0] ReadData3,
    input  logic          PendSet,
    input  logic [AW-1:0] PendReg,
    output logic          Busy1,
    output logic          Busy2,
    output logic          Busy3
);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic wr0_ok;
    logic wr1_ok;
    logic pset_ok;

    // Address is usable for storage: inside the array and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({{(32-AW){1'b0}}, a} < 32'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr0_ok  = RegWre0 && addr_ok(WriteReg0);
    assign wr1_ok  = RegWre1 && addr_ok(WriteReg1);
    assign pset_ok = PendSet && addr_ok(PendReg);

    // Port 1 is applied after port 0 so it wins; pending set is applied last so a new producer wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr0_ok) begin
            regs_d[WriteReg0] = WriteData0;
            pend_d[WriteReg0] = 1'b0;
        end
        if (wr1_ok) begin
            regs_d[WriteReg1] = WriteData1;
            pend_d[WriteReg1] = 1'b0;
        end
        if (pset_ok) begin
            pend_d[PendReg] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    logic [AW-1:0] raddr [3];
    logic [DW-1:0] rdata [3];
    logic          rbusy [3];

    assign raddr[0] = ReadReg1;
    assign raddr[1] = ReadReg2;
    assign raddr[2] = ReadReg3;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rdata[k] = '0;
            rbusy[k] = 1'b0;
            if (!Reset && addr_ok(raddr[k])) begin
                if (BYPASS && wr1_ok && (WriteReg1 == raddr[k])) begin
                    rdata[k] = WriteData1;
                end else if (BYPASS && wr0_ok && (WriteReg0 == raddr[k])) begin
                    rdata[k] = WriteData0;
                end else begin
                    rdata[k] = regs_q[raddr[k]];
                    rbusy[k] = pend_q[raddr[k]];
                end
            end
        end
    end

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];
    assign ReadData3 = rdata[2];
    assign Busy1     = rbusy[0];
    assign Busy2     = rbusy[1];
    assign Busy3     = rbusy[2];

endmodule
